// File: rtl/height_history_writer.sv
// height_history_writer
//   Accepts clamped height samples over valid/ready, holds the newest one and
//   shifts it into a 10-deep history on the next vblank rising edge, so the
//   display never changes mid-frame.
//   Optional build macro: HIST_DEDUP_EN -- a commit whose value equals the
//   current hist_0 is suppressed (no shift, count unchanged).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no sample held; waiting for an accepted sample
//   PENDING | a sample is held; committed at the next vblank rise
module height_history_writer #(
  parameter int MAX_HEIGHT = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_valid,
  input  logic [7:0] sample_height,
  output logic       sample_ready,
  input  logic       vblank,
  input  logic       clear,
  output logic [7:0] hist_0,
  output logic [7:0] hist_1,
  output logic [7:0] hist_2,
  output logic [7:0] hist_3,
  output logic [7:0] hist_4,
  output logic [7:0] hist_5,
  output logic [7:0] hist_6,
  output logic [7:0] hist_7,
  output logic [7:0] hist_8,
  output logic [7:0] hist_9,
  output logic [3:0] count,
  output logic       drop
);

  localparam int          HIST_DEPTH = 10;
  localparam logic [7:0]  MAX_H      = MAX_HEIGHT[7:0];
  localparam logic [3:0]  COUNT_MAX  = 4'd10;

  typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       vblank_q;
  logic [7:0] pending_q;
  logic [7:0] hist_q [HIST_DEPTH];

  logic       accept;
  logic       vblank_rise;
  logic       commit;
  logic       shift_en;
  logic       drop_next;
  logic [7:0] clamped;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; clear wins over everything else
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = PENDING;
        PENDING: if (vblank_rise && !accept) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/control decode; ready depends only on clear since both states accept
  always_comb begin
    sample_ready = ~clear;
    accept       = sample_valid & ~clear;
    vblank_rise  = vblank & ~vblank_q;
    commit       = (state_q == PENDING) & vblank_rise & ~clear;
`ifdef HIST_DEDUP_EN
    shift_en     = commit & (pending_q != hist_q[0]);
`else
    shift_en     = commit;
`endif
    // A same-cycle commit consumes the old value, so that overwrite is not a drop
    drop_next    = accept & (state_q == PENDING) & ~vblank_rise;
    clamped      = (sample_height > MAX_H) ? MAX_H : sample_height;
  end

  // vblank edge detector and pending-sample register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vblank_q  <= 1'b0;
      pending_q <= 8'd0;
    end else begin
      vblank_q <= vblank;
      if (clear)       pending_q <= 8'd0;
      else if (accept) pending_q <= clamped;
    end
  end

  // History shift register, saturating entry count and drop pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= 8'd0;
      count <= 4'd0;
      drop  <= 1'b0;
    end else begin
      drop <= drop_next;
      if (clear) begin
        for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= 8'd0;
        count <= 4'd0;
      end else if (shift_en) begin
        for (int i = HIST_DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
        hist_q[0] <= pending_q;
        if (count != COUNT_MAX) count <= count + 4'd1;
      end
    end
  end

  assign hist_0 = hist_q[0];
  assign hist_1 = hist_q[1];
  assign hist_2 = hist_q[2];
  assign hist_3 = hist_q[3];
  assign hist_4 = hist_q[4];
  assign hist_5 = hist_q[5];
  assign hist_6 = hist_q[6];
  assign hist_7 = hist_q[7];
  assign hist_8 = hist_q[8];
  assign hist_9 = hist_q[9];

endmodule

// File: tb/tb_height_history_writer.sv
// Directed bench for height_history_writer: clamp, frame-aligned commit,
// saturation, drop/overwrite, same-cycle accept+commit, clear, reset, dedup.
module tb_height_history_writer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_valid;
  logic [7:0] sample_height;
  logic       sample_ready;
  logic       vblank;
  logic       clear;
  logic [7:0] hist [10];
  logic [3:0] count;
  logic       drop;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  height_history_writer #(.MAX_HEIGHT(99)) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_valid(sample_valid), .sample_height(sample_height),
    .sample_ready(sample_ready), .vblank(vblank), .clear(clear),
    .hist_0(hist[0]), .hist_1(hist[1]), .hist_2(hist[2]), .hist_3(hist[3]),
    .hist_4(hist[4]), .hist_5(hist[5]), .hist_6(hist[6]), .hist_7(hist[7]),
    .hist_8(hist[8]), .hist_9(hist[9]),
    .count(count), .drop(drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    sample_valid  = 1'b1;
    sample_height = v;
    step();
    sample_valid  = 1'b0;
  endtask

  task automatic frame();
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0; sample_valid = 1'b0; sample_height = 8'd0;
    vblank = 1'b0; clear = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk("reset_count", count, 0);
    chk("reset_hist0", hist[0], 0);
    chk("reset_drop", drop, 0);
    chk("reset_ready", sample_ready, 1);

    // 42 held until the vblank edge
    send(8'd42);
    chk("hold_hist0_a", hist[0], 0);
    step(); step();
    chk("hold_hist0_b", hist[0], 0);
    chk("hold_count", count, 0);
    frame();
    chk("c42_hist0", hist[0], 42);
    chk("c42_hist1", hist[1], 0);
    chk("c42_hist9", hist[9], 0);
    chk("c42_count", count, 1);

    // clamp boundaries
    send(8'd200); frame();
    chk("clamp200", hist[0], 99);
    send(8'd99); frame();
    chk("clamp99", hist[0], 99);
    send(8'd0); frame();
    chk("clamp0", hist[0], 0);
    chk("clamp_count", count, 4);

    // wipe, then fill past depth
    clear = 1'b1; #1;
    chk("clear_ready_idle", sample_ready, 0);
    step();
    clear = 1'b0;
    chk("clear_count_a", count, 0);
    for (int i = 1; i <= 12; i++) begin
      send(i[7:0]);
      frame();
    end
    for (int k = 0; k < 10; k++) chk($sformatf("fill_hist%0d", k), hist[k], 12 - k);
    chk("fill_count", count, 10);

    // overwrite within a frame -> single drop, newest wins
    send(8'd5);
    chk("drop_first", drop, 0);
    send(8'd7);
    chk("drop_pulse", drop, 1);
    step();
    chk("drop_cleared", drop, 0);
    // sample 9 arrives on the same edge as the vblank rise: 7 commits, no drop
    sample_valid = 1'b1; sample_height = 8'd9; vblank = 1'b1;
    step();
    sample_valid = 1'b0; vblank = 1'b0;
    chk("same_hist0", hist[0], 7);
    chk("same_hist1", hist[1], 12);
    chk("same_drop", drop, 0);
    chk("same_count", count, 10);
    step();
    frame();
    chk("next_hist0", hist[0], 9);
    chk("next_hist1", hist[1], 7);
    chk("next_hist2", hist[2], 12);
    // rise while idle changes nothing
    frame();
    chk("idle_hist0", hist[0], 9);
    chk("idle_hist1", hist[1], 7);
    chk("idle_count", count, 10);

    // clear while pending with history full
    send(8'd50);
    clear = 1'b1; sample_valid = 1'b1; sample_height = 8'd60; #1;
    chk("clear_ready", sample_ready, 0);
    step();
    clear = 1'b0; sample_valid = 1'b0;
    chk("clear_count", count, 0);
    for (int k = 0; k < 10; k++) chk($sformatf("clear_hist%0d", k), hist[k], 0);
    frame();
    chk("post_clear_hist0", hist[0], 0);
    chk("post_clear_count", count, 0);

    // accept and rise together while idle: capture only
    sample_valid = 1'b1; sample_height = 8'd33; vblank = 1'b1;
    step();
    sample_valid = 1'b0; vblank = 1'b0;
    chk("idle_acc_hist0", hist[0], 0);
    chk("idle_acc_count", count, 0);
    step();
    frame();
    chk("idle_acc_commit", hist[0], 33);
    chk("idle_acc_count2", count, 1);

    // repeated value in successive frames
    clear = 1'b1; step(); clear = 1'b0;
    send(8'd30); frame();
    send(8'd30); frame();
`ifdef HIST_DEDUP_EN
    chk("dup_count", count, 1);
    chk("dup_hist0", hist[0], 30);
    chk("dup_hist1", hist[1], 0);
`else
    chk("dup_count", count, 2);
    chk("dup_hist0", hist[0], 30);
    chk("dup_hist1", hist[1], 30);
`endif

    // reset while pending loses the sample silently
    send(8'd44);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst_pend_drop", drop, 0);
    chk("rst_pend_count", count, 0);
    chk("rst_pend_ready", sample_ready, 1);
    frame();
    chk("rst_pend_hist0", hist[0], 0);
    chk("rst_pend_count2", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
